// File: rtl/mode_key_ctrl.sv
// Front-panel mode controller: two debounced push-buttons drive the
// OFFLINE / RUN / SET operating-mode state machine.

module mode_key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= key;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == D_LAST) begin
                // Flip on the edge that would make the count reach DEBOUNCE_CYCLES.
                level <= sync_b;
                cnt   <= '0;
                press <= sync_b;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end
endmodule

// state      | meaning
// ST_OFFLINE | system offline, only the online key is honoured
// ST_RUN     | normal operation
// ST_SET     | editing duration field set_sel, timeout running
module mode_key_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_online,
    input  logic       key_set,
    output logic       online,
    output logic       set,
    output logic [1:0] set_sel,
    output logic       set_done,
    output logic       set_abort
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFFLINE = 2'd0,
        ST_RUN     = 2'd1,
        ST_SET     = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          done_d, abort_d;
    logic          press_online, press_set;

    mode_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_online (
        .clk   (clk),
        .rst   (rst),
        .key   (key_online),
        .press (press_online)
    );

    mode_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk   (clk),
        .rst   (rst),
        .key   (key_set),
        .press (press_set)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_OFFLINE;
            sel_q     <= 2'd0;
            tcnt_q    <= '0;
            online    <= 1'b0;
            set       <= 1'b0;
            set_sel   <= 2'd0;
            set_done  <= 1'b0;
            set_abort <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            tcnt_q    <= tcnt_d;
            online    <= (state_d != ST_OFFLINE);
            set       <= (state_d == ST_SET);
            set_sel   <= sel_d;
            set_done  <= done_d;
            set_abort <= abort_d;
        end
    end

    // The online key always takes priority; a set press beats the timeout.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tcnt_d  = tcnt_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            ST_OFFLINE: begin
                sel_d  = 2'd0;
                tcnt_d = '0;
                if (press_online) state_d = ST_RUN;
            end
            ST_RUN: begin
                sel_d  = 2'd0;
                tcnt_d = '0;
                if (press_online)   state_d = ST_OFFLINE;
                else if (press_set) state_d = ST_SET;
            end
            ST_SET: begin
                if (press_online) begin
                    state_d = ST_OFFLINE;
                    sel_d   = 2'd0;
                    tcnt_d  = '0;
                    abort_d = 1'b1;
                end else if (press_set) begin
                    tcnt_d = '0;
                    if (sel_q == 2'd2) begin
                        state_d = ST_RUN;
                        sel_d   = 2'd0;
                        done_d  = 1'b1;
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end else if (tcnt_q == T_LAST) begin
                    state_d = ST_RUN;
                    sel_d   = 2'd0;
                    tcnt_d  = '0;
                    abort_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_OFFLINE;
                sel_d   = 2'd0;
                tcnt_d  = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_mode_key_ctrl.sv
// Bench for mode_key_ctrl: directed test-plan phases plus random key activity,
// all checked every cycle against a window-based behavioural model.

module tb_mode_key_ctrl;
    localparam int D = 4;
    localparam int T = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_online = 1'b0;
    logic       key_set = 1'b0;
    logic       online, set, set_done, set_abort;
    logic [1:0] set_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mode_key_ctrl #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_online (key_online),
        .key_set    (key_set),
        .online     (online),
        .set        (set),
        .set_sel    (set_sel),
        .set_done   (set_done),
        .set_abort  (set_abort)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a key level is accepted once the raw samples seen two
    // edges earlier have disagreed with the accepted level for D edges in a row.
    logic [15:0] hist_on = '0, hist_st = '0;
    bit  db_on = 0, db_st = 0, pr_on = 0, pr_st = 0;
    bit  done_m = 0, abort_m = 0, armed = 0;
    int  mode = 0, sel = 0, idle = 0;   // mode: 0 offline, 1 run, 2 set

    function automatic bit window_flip(input logic [15:0] h, input bit db);
        for (int i = 2; i <= D + 1; i++)
            if (h[i] == db) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hist_on = '0; hist_st = '0;
            db_on = 0; db_st = 0; pr_on = 0; pr_st = 0;
            mode = 0; sel = 0; idle = 0;
            done_m = 0; abort_m = 0; armed = 1;
        end else begin
            done_m = 0; abort_m = 0;
            case (mode)
                0: if (pr_on) mode = 1;
                1: if (pr_on) mode = 0;
                   else if (pr_st) begin mode = 2; sel = 0; idle = 0; end
                default: begin
                    if (pr_on) begin
                        mode = 0; sel = 0; abort_m = 1;
                    end else if (pr_st) begin
                        if (sel == 2) begin mode = 1; sel = 0; done_m = 1; end
                        else begin sel++; idle = 0; end
                    end else begin
                        idle++;
                        if (idle == T) begin mode = 1; sel = 0; abort_m = 1; end
                    end
                end
            endcase
            hist_on = {hist_on[14:0], key_online};
            hist_st = {hist_st[14:0], key_set};
            pr_on = 0; pr_st = 0;
            if (window_flip(hist_on, db_on)) begin db_on = !db_on; pr_on = db_on; end
            if (window_flip(hist_st, db_st)) begin db_st = !db_st; pr_st = db_st; end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check_val("online",  {31'd0, online},    {31'd0, mode != 0});
            check_val("set",     {31'd0, set},       {31'd0, mode == 2});
            check_val("set_sel", {30'd0, set_sel},   sel);
            check_val("done",    {31'd0, set_done},  {31'd0, done_m});
            check_val("abort",   {31'd0, set_abort}, {31'd0, abort_m});
            check_val("excl",    {31'd0, set_done & set_abort}, 32'd0);
        end
    end

    task automatic drive(input bit on, input bit st, input int n);
        key_online = on;
        key_set    = st;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_set_key();
        drive(0, 1, 10);
        drive(0, 0, 10);
    endtask

    task automatic press_online_key();
        drive(1, 0, 10);
        drive(0, 0, 10);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // idle after reset
        drive(0, 0, 100);
        check_val("idle_online", {31'd0, online}, 32'd0);

        // press latency: key sampled high from edge 0, online visible after edge 6
        key_online = 1'b1;
        repeat (6) @(posedge clk);
        #1 check_val("lat_edge5", {31'd0, online}, 32'd0);
        @(posedge clk);
        #1 check_val("lat_edge6", {31'd0, online}, 32'd1);
        drive(1, 0, 4);
        drive(0, 0, 10);
        press_online_key();
        check_val("second_press", {31'd0, online}, 32'd0);

        // bounce rejection in RUN
        press_online_key();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 2);
            drive(0, 0, 2);
        end
        drive(0, 0, 10);
        drive(1, 0, 3);
        drive(0, 0, 10);
        check_val("bounce_run", {31'd0, online}, 32'd1);

        // four set presses
        press_set_key();
        check_val("p1_set", {31'd0, set}, 32'd1);
        check_val("p1_sel", {30'd0, set_sel}, 32'd0);
        press_set_key();
        check_val("p2_sel", {30'd0, set_sel}, 32'd1);
        press_set_key();
        check_val("p3_sel", {30'd0, set_sel}, 32'd2);
        press_set_key();
        check_val("p4_set", {31'd0, set}, 32'd0);
        check_val("p4_online", {31'd0, online}, 32'd1);

        // timeout abort from field 1
        press_set_key();
        press_set_key();
        drive(0, 0, 60);
        check_val("tmo_set", {31'd0, set}, 32'd0);
        check_val("tmo_online", {31'd0, online}, 32'd1);

        // online-key abort from field 1
        press_set_key();
        press_set_key();
        press_online_key();
        check_val("abort_online", {31'd0, online}, 32'd0);

        // both keys together in RUN
        press_online_key();
        drive(1, 1, 10);
        drive(0, 0, 10);
        check_val("both_online", {31'd0, online}, 32'd0);

        // reset in the middle of SET
        press_online_key();
        press_set_key();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_val("rst_online", {31'd0, online}, 32'd0);
        check_val("rst_abort", {31'd0, set_abort}, 32'd0);
        drive(0, 0, 10);

        // random key activity with occasional long idles and resets
        for (int k = 0; k < 700; k++) begin
            int hold;
            hold = ($urandom_range(0, 9) == 0) ? $urandom_range(45, 70) : $urandom_range(1, 9);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), hold);
        end
        drive(0, 0, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mode_key_ctrl.md
# mode_key_ctrl

Front-panel mode controller for the traffic light system. It synchronizes and debounces the two raw push-buttons and runs the operating-mode state machine. It drives the `online` and `set` mode flags consumed by the LED indicator driver and by the timing core, plus the index of the duration field currently being edited. It sits between the board push-buttons and the rest of the control system.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles before a key level is accepted (10 ms at 100 MHz); legal range ≥ 2.
- `TIMEOUT_CYCLES`, default 1000000000: cycles without an accepted press in SET before an automatic abort (10 s at 100 MHz); legal range ≥ 2.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_online` in 1: raw, asynchronous, bouncing online/offline push-button; active-high.
- `key_set` in 1: raw, asynchronous, bouncing set push-button; active-high.
- `online` out 1: high in RUN and SET.
- `set` out 1: high in SET only.
- `set_sel` out 2: field being edited in SET: 0 = red, 1 = green, 2 = yellow; 0 outside SET.
- `set_done` out 1: one-cycle pulse when SET exits normally after field 2.
- `set_abort` out 1: one-cycle pulse when SET exits by timeout or by an online press.

## Operation
- **Key path**, per key:
  - 2-flop synchronizer.
  - Debounce counter: counts while the synchronized level differs from the debounced level and resets to 0 whenever they match. When the count reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - Press pulse: one cycle, generated on the debounced 0→1 transition only. Releases generate nothing.
- **State machine**, states OFFLINE, RUN, SET:
  - OFFLINE: online press → RUN. Set presses are ignored.
  - RUN: online press → OFFLINE. Set press → SET with `set_sel` = 0 and the timeout counter cleared.
  - SET, set press:
    - With `set_sel` < 2: increment `set_sel` and clear the timeout counter.
    - With `set_sel` = 2: go to RUN and pulse `set_done`.
  - SET, online press: go to OFFLINE and pulse `set_abort`.
  - SET, timeout counter reaches `TIMEOUT_CYCLES`: go to RUN and pulse `set_abort`.
- **Simultaneous events** in the same cycle:
  - Online press and set press: online press wins; the set press is discarded.
  - Timeout and set press: the set press wins and the timeout counter clears.
  - Timeout and online press: go to OFFLINE with a single `set_abort` pulse.
- **Outputs** are registered and decoded from the state: `online`, `set`, `set_sel`. `set_done` and `set_abort` are never high in the same cycle.
- **Counter widths:**
  - Debounce counter: $clog2(`DEBOUNCE_CYCLES`+1).
  - Timeout counter: $clog2(`TIMEOUT_CYCLES`+1).
  - Neither counter wraps: each saturates or clears as described above.

## Timing
- **Reset** (synchronous, effective on the rising edge where `rst` is 1):
  - State = OFFLINE.
  - `online` = 0, `set` = 0, `set_sel` = 0, `set_done` = 0, `set_abort` = 0.
  - Synchronizers, debounced levels and all counters = 0.
  - Reset mid-SET aborts silently: no `set_abort` pulse.
- **Key held through reset:** the debounced level is 0 after reset, so the held key registers as a fresh press once debounced.
- **Press latency:** let edge 0 be the first edge at which the synchronizer's first flop samples the key high, with the key held stable afterwards. Then:
  - The synchronized level is high after edge 1.
  - The debounced level flips at edge 1 + `DEBOUNCE_CYCLES`.
  - The press pulse is high during the following cycle.
  - State and outputs update at edge 2 + `DEBOUNCE_CYCLES`.
- **Bounce rejection:** any glitch shorter than `DEBOUNCE_CYCLES` cycles produces no press and no state change.
- **Press rate:** at most one press per key per debounced press/release cycle.
- **Pulse timing:** `set_done` and `set_abort` are high for exactly the one cycle in which the state transition becomes visible on `online`/`set`.

## Test plan
Run with `DEBOUNCE_CYCLES` = 4, `TIMEOUT_CYCLES` = 50.

1. Reset then idle, keys low → `online` = 0, `set` = 0, `set_sel` = 0, no pulses for 100 cycles.
2. `key_online` high and held from edge 0 → `online` = 1 visible at edge 6; release, then second press → `online` = 0.
3. In RUN, `key_online` toggling every 2 cycles for 20 cycles, then low → no state change. A 3-cycle high pulse is also rejected.
4. In RUN, four clean `key_set` presses:
   - 1st → `set` = 1, `set_sel` = 0.
   - 2nd → `set_sel` = 1.
   - 3rd → `set_sel` = 2.
   - 4th → `set` = 0, `online` = 1, one-cycle `set_done`.
5. In SET with `set_sel` = 1, no presses for 50 cycles → RUN, `set_sel` = 0, one-cycle `set_abort`. Repeat with an online press instead → OFFLINE with `set_abort`.
6. Both keys pressed in the same cycle while in RUN → OFFLINE, `set` never asserted. Separately, assert `rst` for 1 cycle mid-SET → all outputs 0 at the next cycle, no `set_abort`.
